// File: rtl/blackjack_ctrl.sv
// Blackjack round controller. It deals two cards each to the player and the
// dealer, runs the player's turn from the hit/stay buttons, plays the dealer
// to DEALER_STAND, and then registers the outcome.
// Ports:
//   clk, rst           - system clock; asynchronous active-high reset
//   hit, stay          - debounced button levels; each rising edge is one action
//   card_vld, card_val - card source handshake and rank (1=ace, 2..10)
//   card_req           - registered request for one card
//   p_score, d_score   - best player and dealer scores
//   result             - 00 none, 01 player win, 10 player lose, 11 push
//   busy               - high in every state except IDLE and RESULT
module blackjack_ctrl #(
    parameter int unsigned DEALER_STAND = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       stay,
    input  logic       card_vld,
    input  logic [3:0] card_val,
    output logic       card_req,
    output logic [4:0] p_score,
    output logic [4:0] d_score,
    output logic [1:0] result,
    output logic       busy
);

    localparam int unsigned SW = 5;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_PUSH = 2'b11;

    typedef enum logic [3:0] {
        IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
        PLAYER, P_HIT, DEALER, D_HIT, RESULT
    } state_t;

    state_t          state, state_n;
    logic            hit_q, stay_q, armed;
    logic [SW-1:0]   p_hard, d_hard, p_hard_n, d_hard_n;
    logic            p_ace, d_ace, p_ace_n, d_ace_n;
    logic            card_req_n;
    logic [1:0]      result_n;

    logic            hit_edge_c, stay_edge_c, card_acc_c;
    logic [SW-1:0]   card_norm_c;
    logic [SW-1:0]   p_add_hard_c, d_add_hard_c;
    logic            p_add_ace_c, d_add_ace_c;

    // Best score: an ace counts 11 when that does not bust the hand.
    function automatic logic [SW-1:0] best_score(input logic [SW-1:0] hard,
                                                 input logic          ace);
        return (ace && hard <= SW'(11)) ? hard + SW'(10) : hard;
    endfunction

    // Edges are qualified by armed so a level already high at reset release is not an edge.
    assign hit_edge_c  = armed & hit  & ~hit_q;
    assign stay_edge_c = armed & stay & ~stay_q;
    assign card_acc_c  = card_req & card_vld;

    // Rank clean-up: 0 reads as an ace, anything above 10 as a ten.
    always_comb begin
        card_norm_c = SW'(card_val);
        if (card_val == 4'd0)
            card_norm_c = SW'(1);
        else if (card_val > 4'd10)
            card_norm_c = SW'(10);
    end

    assign p_add_hard_c = p_hard + card_norm_c;
    assign d_add_hard_c = d_hard + card_norm_c;
    assign p_add_ace_c  = p_ace | (card_norm_c == SW'(1));
    assign d_add_ace_c  = d_ace | (card_norm_c == SW'(1));

    // State register plus all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hit_q    <= 1'b0;
            stay_q   <= 1'b0;
            armed    <= 1'b0;
            p_hard   <= '0;
            d_hard   <= '0;
            p_ace    <= 1'b0;
            d_ace    <= 1'b0;
            card_req <= 1'b0;
            p_score  <= '0;
            d_score  <= '0;
            result   <= RES_NONE;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            hit_q    <= hit;
            stay_q   <= stay;
            armed    <= 1'b1;
            p_hard   <= p_hard_n;
            d_hard   <= d_hard_n;
            p_ace    <= p_ace_n;
            d_ace    <= d_ace_n;
            card_req <= card_req_n;
            p_score  <= best_score(p_hard_n, p_ace_n);
            d_score  <= best_score(d_hard_n, d_ace_n);
            result   <= result_n;
            busy     <= (state_n != IDLE) && (state_n != RESULT);
        end
    end

    // Next-state, hand accumulation and outcome decision.
    always_comb begin
        state_n    = state;
        p_hard_n   = p_hard;
        d_hard_n   = d_hard;
        p_ace_n    = p_ace;
        d_ace_n    = d_ace;
        card_req_n = card_req;
        result_n   = result;

        case (state)
            IDLE, RESULT: begin
                card_req_n = 1'b0;
                if (hit_edge_c) begin
                    state_n    = DEAL_P1;
                    p_hard_n   = '0;
                    d_hard_n   = '0;
                    p_ace_n    = 1'b0;
                    d_ace_n    = 1'b0;
                    result_n   = RES_NONE;
                    card_req_n = 1'b1;
                end
            end
            DEAL_P1, DEAL_P2: begin
                card_req_n = 1'b1;
                if (card_acc_c) begin
                    p_hard_n = p_add_hard_c;
                    p_ace_n  = p_add_ace_c;
                    state_n  = (state == DEAL_P1) ? DEAL_D1 : DEAL_D2;
                end
            end
            DEAL_D1, DEAL_D2: begin
                card_req_n = 1'b1;
                if (card_acc_c) begin
                    d_hard_n = d_add_hard_c;
                    d_ace_n  = d_add_ace_c;
                    if (state == DEAL_D1) begin
                        state_n = DEAL_P2;
                    end else begin
                        state_n    = PLAYER;
                        card_req_n = 1'b0;
                    end
                end
            end
            PLAYER: begin
                card_req_n = 1'b0;
                // Stay takes priority over a simultaneous hit.
                if (p_score == SW'(21) || stay_edge_c) begin
                    state_n = DEALER;
                end else if (hit_edge_c) begin
                    state_n    = P_HIT;
                    card_req_n = 1'b1;
                end
            end
            P_HIT: begin
                card_req_n = 1'b1;
                if (card_acc_c) begin
                    p_hard_n   = p_add_hard_c;
                    p_ace_n    = p_add_ace_c;
                    card_req_n = 1'b0;
                    if (best_score(p_add_hard_c, p_add_ace_c) > SW'(21)) begin
                        state_n  = RESULT;
                        result_n = RES_LOSE;
                    end else begin
                        state_n = PLAYER;
                    end
                end
            end
            DEALER: begin
                card_req_n = 1'b0;
                if (d_score < SW'(DEALER_STAND)) begin
                    state_n    = D_HIT;
                    card_req_n = 1'b1;
                end else begin
                    state_n = RESULT;
                    if (d_score > SW'(21) || p_score > d_score)
                        result_n = RES_WIN;
                    else if (p_score < d_score)
                        result_n = RES_LOSE;
                    else
                        result_n = RES_PUSH;
                end
            end
            D_HIT: begin
                card_req_n = 1'b1;
                if (card_acc_c) begin
                    d_hard_n   = d_add_hard_c;
                    d_ace_n    = d_add_ace_c;
                    card_req_n = 1'b0;
                    state_n    = DEALER;
                end
            end
            default: begin
                state_n    = IDLE;
                card_req_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_blackjack_ctrl.sv
// Scoreboard bench for blackjack_ctrl: the stimulus pushes hand-computed round
// outcomes, and a monitor compares each outcome when busy falls at round end.
module tb_blackjack_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       hit, stay;
    logic       card_vld;
    logic [3:0] card_val;
    logic       card_req;
    logic [4:0] p_score, d_score;
    logic [1:0] result;
    logic       busy;

    typedef struct packed {
        logic [4:0] p;
        logic [4:0] d;
        logic [1:0] r;
    } exp_t;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [3:0] cards[$];
    exp_t       exp_q[$];

    blackjack_ctrl #(.DEALER_STAND(17)) dut (
        .clk(clk), .rst(rst), .hit(hit), .stay(stay),
        .card_vld(card_vld), .card_val(card_val), .card_req(card_req),
        .p_score(p_score), .d_score(d_score), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Card source: presents the next queued card while card_req is high.
    initial begin
        card_vld = 1'b0;
        card_val = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst && card_req && cards.size() > 0) begin
                card_vld = 1'b1;
                card_val = cards.pop_front();
                @(negedge clk);
                card_vld = 1'b0;
            end
        end
    end

    // Monitor: a round outcome is presented when busy falls outside reset.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_outcome", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("p_score", int'(p_score), int'(e.p));
                    check("d_score", int'(d_score), int'(e.d));
                    check("result",  int'(result),  int'(e.r));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic press_hit();
        @(negedge clk); hit = 1'b1;
        @(negedge clk); hit = 1'b0;
    endtask

    task automatic press_stay();
        @(negedge clk); stay = 1'b1;
        @(negedge clk); stay = 1'b0;
    endtask

    task automatic press_both();
        @(negedge clk); hit = 1'b1; stay = 1'b1;
        @(negedge clk); hit = 1'b0; stay = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(name, 0, 1);
    endtask

    // Player turn reached: every queued card taken and no request pending.
    task automatic wait_player(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cards.size() == 0 && !card_vld && !card_req && busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(name, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int bad;
        rst = 1'b1; hit = 1'b0; stay = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({card_req, p_score, d_score, result, busy}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Push: 17 vs 17.
        cards = '{4'd10, 4'd9, 4'd7, 4'd8};
        exp_q.push_back('{p: 5'd17, d: 5'd17, r: 2'b11});
        press_hit();
        wait_player("timeout_push_deal");
        check("push_p_dealt", int'(p_score), 17);
        press_stay();
        wait_idle("timeout_push");

        // Soft ace turns hard on a hit; dealer busts.
        cards = '{4'd1, 4'd6, 4'd5, 4'd10};
        exp_q.push_back('{p: 5'd13, d: 5'd22, r: 2'b01});
        press_hit();
        wait_player("timeout_ace_deal");
        check("ace_soft16", int'(p_score), 16);
        check("ace_dealer16", int'(d_score), 16);
        cards.push_back(4'd7);
        press_hit();
        wait_player("timeout_ace_hit");
        check("ace_hard13", int'(p_score), 13);
        cards.push_back(4'd6);
        press_stay();
        wait_idle("timeout_ace");

        // Player busts; dealer never plays.
        cards = '{4'd10, 4'd5, 4'd6, 4'd7};
        exp_q.push_back('{p: 5'd25, d: 5'd12, r: 2'b10});
        press_hit();
        wait_player("timeout_bust_deal");
        cards.push_back(4'd9);
        press_hit();
        wait_idle("timeout_bust");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (card_req) bad++;
        end
        check("no_req_after_bust", bad, 0);

        // Dealer soft 17 stands.
        cards = '{4'd10, 4'd1, 4'd9, 4'd6};
        exp_q.push_back('{p: 5'd19, d: 5'd17, r: 2'b01});
        press_hit();
        wait_player("timeout_soft17_deal");
        check("dealer_soft17", int'(d_score), 17);
        press_stay();
        wait_idle("timeout_soft17");

        // Rank clean-up (0 -> ace, 13/15 -> 10); natural 21 skips the player turn.
        cards = '{4'd0, 4'd13, 4'd15, 4'd9};
        exp_q.push_back('{p: 5'd21, d: 5'd19, r: 2'b01});
        press_hit();
        wait_idle("timeout_natural");

        // Simultaneous hit and stay: stay wins, no player card.
        cards = '{4'd10, 4'd5, 4'd6, 4'd7};
        exp_q.push_back('{p: 5'd16, d: 5'd17, r: 2'b10});
        press_hit();
        wait_player("timeout_both_deal");
        cards.push_back(4'd5);
        press_both();
        wait_idle("timeout_both");

        // Held hit gives exactly one player card.
        cards = '{4'd2, 4'd3, 4'd4, 4'd5};
        exp_q.push_back('{p: 5'd8, d: 5'd21, r: 2'b10});
        press_hit();
        wait_player("timeout_held_deal");
        cards.push_back(4'd2);
        cards.push_back(4'd3);
        @(negedge clk); hit = 1'b1;
        repeat (30) @(negedge clk);
        hit = 1'b0;
        repeat (2) @(negedge clk);
        check("held_hit_cards_left", cards.size(), 1);
        check("held_hit_p_score", int'(p_score), 8);
        cards.push_back(4'd10);
        press_stay();
        wait_idle("timeout_held");

        // Stalled card source in DEAL_D1, then reset mid-handshake.
        cards = '{4'd10};
        press_hit();
        for (int i = 0; i < 100 && cards.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!card_req || !busy) bad++;
        end
        check("stall_holds_req", bad, 0);
        check("stall_p_score", int'(p_score), 10);
        rst = 1'b1;
        @(negedge clk);
        check("midwait_reset", int'({card_req, p_score, d_score, result, busy}), 0);
        hit = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("held_hit_after_reset", int'({busy, card_req}), 0);
        hit = 1'b0;
        repeat (4) @(negedge clk);

        check("pending_outcomes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
